// File: rtl/seq_responder.sv
`default_nettype none
// ============================================================================
// Module      : seq_responder
// Description : Watches the C -> B -> A enabling sequence and answers every
//               match with JLEN cycles of J followed by a one-cycle K.
//               X synchronously aborts all detection and in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_responder #(
  parameter int WIN_MIN = 1,  // minimum C-to-B distance, >= 1
  parameter int WIN_MAX = 3,  // maximum C-to-B distance, WIN_MIN..8
  parameter int JLEN    = 4,  // J cycles per response, 1..15
  parameter int CNT_W   = 8   // width of the completed-response counter
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             X,
  output logic             J,
  output logic             K,
  output logic             TRIG,
  output logic             BUSY,
  output logic             ABORT,
  output logic [CNT_W-1:0] RESP_CNT
);

  // Bit i of the history holds C as sampled i+1 edges ago.
  logic [WIN_MAX-1:0] c_hist_q, c_hist_d;
  logic               b_ok_q, b_ok_d;
  // Stage i of the pipeline is a response that was triggered i+1 edges ago.
  logic [JLEN:0]      pipe_q, pipe_d;
  logic               trig_q, trig_d;
  logic               j_q, j_d;
  logic               k_q, k_d;
  logic               busy_q, busy_d;
  logic               abort_q, abort_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_hit;

  // C was seen somewhere inside the allowed C-to-B window.
  always_comb begin
    c_hit = 1'b0;
    for (int i = WIN_MIN - 1; i < WIN_MAX; i++) begin
      c_hit = c_hit | c_hist_q[i];
    end
  end

  // Sequence detection and response pipeline; X overrides everything sampled
  // on the same edge so an abort can never be followed by a stray trigger.
  always_comb begin
    trig_d      = A & b_ok_q;
    b_ok_d      = B & c_hit;
    c_hist_d[0] = C;
    for (int i = 1; i < WIN_MAX; i++) begin
      c_hist_d[i] = c_hist_q[i-1];
    end
    pipe_d[0] = trig_d;
    for (int i = 1; i <= JLEN; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    abort_d = 1'b0;
    if (X) begin
      trig_d   = 1'b0;
      b_ok_d   = 1'b0;
      c_hist_d = '0;
      pipe_d   = '0;
      abort_d  = |pipe_q;
    end
  end

  // Output decode from the next pipeline state so J/K/BUSY come straight
  // from flops and line up with the stage they describe.
  always_comb begin
    j_d = 1'b0;
    for (int i = 0; i < JLEN; i++) begin
      j_d = j_d | pipe_d[i];
    end
    k_d    = pipe_d[JLEN];
    busy_d = |pipe_d;
    cnt_d  = cnt_q;
    if (k_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and registered outputs; reset drops everything without an abort.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c_hist_q <= '0;
      b_ok_q   <= 1'b0;
      pipe_q   <= '0;
      trig_q   <= 1'b0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      busy_q   <= 1'b0;
      abort_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      c_hist_q <= c_hist_d;
      b_ok_q   <= b_ok_d;
      pipe_q   <= pipe_d;
      trig_q   <= trig_d;
      j_q      <= j_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      abort_q  <= abort_d;
      cnt_q    <= cnt_d;
    end
  end

  assign J        = j_q;
  assign K        = k_q;
  assign TRIG     = trig_q;
  assign BUSY     = busy_q;
  assign ABORT    = abort_q;
  assign RESP_CNT = cnt_q;

endmodule
`default_nettype wire
